// File: rtl/var_bw_mul_acc_pkg.sv
// var_bw_mul_pkg: shared FSM state type and product widths for the accumulator stage
package var_bw_mul_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  localparam int P_W = 32;
  localparam int HALF_P_W = 16;
endpackage

// File: rtl/var_bw_mul_acc_if.sv
// var_bw_mul_acc_if: product-in / result-out handshake bundle of the accumulator stage
interface var_bw_mul_acc_if #(parameter int ACC_W = 40) ();
  import var_bw_mul_pkg::*;
  logic in_valid;
  logic in_ready;
  logic in_para_mode;
  logic [P_W-1:0] in_p;
  logic in_last;
  logic out_valid;
  logic out_ready;
  logic out_para_mode;
  logic [ACC_W-1:0] out_acc;
  logic [1:0] out_ovf;
  modport master (
    output in_valid, in_para_mode, in_p, in_last, out_ready,
    input  in_ready, out_valid, out_para_mode, out_acc, out_ovf
  );
  modport slave (
    input  in_valid, in_para_mode, in_p, in_last, out_ready,
    output in_ready, out_valid, out_para_mode, out_acc, out_ovf
  );
endinterface

// File: rtl/var_bw_mul_lane_acc.sv
// var_bw_mul_lane_acc: one accumulator lane with carry in/out and sticky carry-out flag
module var_bw_mul_lane_acc #(
  parameter int LW = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_add,
  input  logic          i_cin,
  input  logic [LW-1:0] i_addend,
  output logic [LW-1:0] o_acc,
  output logic          o_cout,
  output logic          o_ovf
);
  logic [LW-1:0] r_acc;
  logic [LW-1:0] w_sum;
  logic          r_ovf;
  // A load adds onto zero, so it can never produce a carry of its own
  assign {o_cout, w_sum} = (i_load ? {(LW+1){1'b0}} : {1'b0, r_acc}) + {1'b0, i_addend} + (LW+1)'(i_cin);
  assign o_acc = r_acc;
  assign o_ovf = r_ovf;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (i_load | i_add) begin
      r_acc <= w_sum;
      r_ovf <= (r_ovf & ~i_load) | o_cout;
    end
endmodule

// File: rtl/var_bw_mul_acc.sv
// var_bw_mul_acc: batch accumulator of multiplier products, one wide lane or two 8-bit-mode lanes
module var_bw_mul_acc
  import var_bw_mul_pkg::*;
#(
  parameter int ACC_W     = 40,
  parameter int BATCH_LEN = 4,
  parameter int CNT_W     = $clog2(BATCH_LEN + 1)
) (
  input logic clk,
  input logic rst,
  var_bw_mul_acc_if.slave bus
);
  localparam int LW = ACC_W / 2;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_live;
  logic             r_mode;
  logic             w_acc;
  logic             w_load;
  logic             w_add;
  logic             w_mode;
  logic             w_close;
  logic             w_cout0;
  logic             w_cout1_unused;
  logic             w_ovf0;
  logic             w_ovf1;
  logic [ACC_W-1:0] w_wide;
  logic [LW-1:0]    w_add0;
  logic [LW-1:0]    w_add1;
  logic [LW-1:0]    w_lane0;
  logic [LW-1:0]    w_lane1;
  // r_live keeps in_ready low until the first edge after reset is released
  assign bus.in_ready      = r_live & ((r_state != HOLD) | bus.out_ready);
  assign w_acc             = bus.in_valid & bus.in_ready;
  assign w_add             = w_acc & (r_state == ACCUM);
  assign w_load            = w_acc & (r_state != ACCUM);
  assign w_mode            = w_add ? r_mode : bus.in_para_mode;
  assign w_wide            = ACC_W'(bus.in_p);
  assign w_add0            = w_mode ? LW'(bus.in_p[HALF_P_W-1:0]) : w_wide[LW-1:0];
  assign w_add1            = w_mode ? LW'(bus.in_p[P_W-1:HALF_P_W]) : w_wide[ACC_W-1:LW];
  assign w_close           = bus.in_last | (w_add ? (r_cnt == CNT_W'(BATCH_LEN - 1)) : (BATCH_LEN == 1));
  assign bus.out_valid     = r_state == HOLD;
  assign bus.out_para_mode = r_mode;
  assign bus.out_acc       = {w_lane1, w_lane0};
  assign bus.out_ovf       = {w_ovf1, w_ovf0 & r_mode};
  var_bw_mul_lane_acc #(.LW(LW)) u_lane0 (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_add    (w_add),
    .i_cin    (1'b0),
    .i_addend (w_add0),
    .o_acc    (w_lane0),
    .o_cout   (w_cout0),
    .o_ovf    (w_ovf0)
  );
  // Carry crosses into the upper lane only when both lanes form one wide value
  var_bw_mul_lane_acc #(.LW(LW)) u_lane1 (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_add    (w_add),
    .i_cin    (w_cout0 & ~w_mode),
    .i_addend (w_add1),
    .o_acc    (w_lane1),
    .o_cout   (w_cout1_unused),
    .o_ovf    (w_ovf1)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_live  <= 1'b0;
      r_mode  <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_load) begin
        r_mode  <= bus.in_para_mode;
        r_cnt   <= CNT_W'(1);
        r_state <= w_close ? HOLD : ACCUM;
      end else if (w_add) begin
        r_cnt   <= r_cnt + CNT_W'(1);
        r_state <= w_close ? HOLD : ACCUM;
      end else if (r_state == HOLD && bus.out_ready) begin
        r_cnt   <= '0;
        r_state <= IDLE;
      end
    end
endmodule

// File: tb/tb_var_bw_mul_acc.sv
// tb_var_bw_mul_acc: two DUT widths checked every cycle against a batch-sum reference model
module tb_var_bw_mul_acc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;

  var_bw_mul_acc_if #(.ACC_W(40)) b0 ();
  var_bw_mul_acc_if #(.ACC_W(34)) b1 ();
  var_bw_mul_acc #(.ACC_W(40), .BATCH_LEN(4)) u0 (.clk(clk), .rst(rst), .bus(b0));
  var_bw_mul_acc #(.ACC_W(34), .BATCH_LEN(8)) u1 (.clk(clk), .rst(rst), .bus(b1));

  // Model: per instance, whole-batch lane sums kept unbounded; wrap/overflow derived at readout
  bit              m_live[2];
  bit              m_hold[2];
  bit              m_mode[2];
  int              m_cnt[2];
  longint unsigned m_s0[2];
  longint unsigned m_s1[2];

  function automatic int lw(int k); return k ? 17 : 20; endfunction
  function automatic int bl(int k); return k ? 8 : 4; endfunction

  function automatic logic [39:0] d_acc(int k); return k ? 40'(b1.out_acc) : b0.out_acc; endfunction
  function automatic logic [1:0] d_ovf(int k); return k ? b1.out_ovf : b0.out_ovf; endfunction
  function automatic logic d_mode(int k); return k ? b1.out_para_mode : b0.out_para_mode; endfunction
  function automatic logic d_ovalid(int k); return k ? b1.out_valid : b0.out_valid; endfunction
  function automatic logic d_irdy(int k); return k ? b1.in_ready : b0.in_ready; endfunction
  function automatic logic i_valid(int k); return k ? b1.in_valid : b0.in_valid; endfunction
  function automatic logic i_mode(int k); return k ? b1.in_para_mode : b0.in_para_mode; endfunction
  function automatic logic i_last(int k); return k ? b1.in_last : b0.in_last; endfunction
  function automatic logic i_ordy(int k); return k ? b1.out_ready : b0.out_ready; endfunction
  function automatic logic [31:0] i_p(int k); return k ? b1.in_p : b0.in_p; endfunction

  function automatic logic [39:0] m_acc(int k);
    longint unsigned mk = (64'd1 << lw(k)) - 1;
    longint unsigned mw = (64'd1 << (2 * lw(k))) - 1;
    return m_mode[k] ? 40'(((m_s1[k] & mk) << lw(k)) | (m_s0[k] & mk)) : 40'(m_s0[k] & mw);
  endfunction

  function automatic logic [1:0] m_ovf(int k);
    return m_mode[k] ? {(m_s1[k] >> lw(k)) != 0, (m_s0[k] >> lw(k)) != 0}
                     : {(m_s0[k] >> (2 * lw(k))) != 0, 1'b0};
  endfunction

  function automatic bit m_rdy(int k);
    return m_live[k] && (!m_hold[k] || i_ordy(k));
  endfunction

  function automatic void m_beat(int k, bit first);
    logic [31:0] p = i_p(k);
    if (first) begin
      m_mode[k] = i_mode(k);
      m_s0[k] = 0;
      m_s1[k] = 0;
      m_cnt[k] = 0;
    end
    m_s0[k] += m_mode[k] ? 64'(p[15:0]) : 64'(p);
    m_s1[k] += m_mode[k] ? 64'(p[31:16]) : 64'd0;
    m_cnt[k]++;
    m_hold[k] = i_last(k) || m_cnt[k] == bl(k);
  endfunction

  function automatic void m_step(int k);
    bit acc = i_valid(k) && m_rdy(k);
    if (!m_live[k]) m_live[k] = 1;
    else if (m_hold[k]) begin
      if (i_ordy(k)) begin
        m_hold[k] = 0;
        m_cnt[k] = 0;
        if (acc) m_beat(k, 1);
      end
    end else if (acc) m_beat(k, m_cnt[k] == 0);
  endfunction

  always @(posedge clk or posedge rst)
    for (int k = 0; k < 2; k++)
      if (rst) begin
        m_live[k] = 0; m_hold[k] = 0; m_mode[k] = 0;
        m_cnt[k] = 0; m_s0[k] = 0; m_s1[k] = 0;
      end else m_step(k);

  function automatic void chk(string nm, logic [39:0] act, logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  always @(negedge clk)
    if (!rst)
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("u%0d in_ready", k), 40'(d_irdy(k)), 40'(m_rdy(k)));
        chk($sformatf("u%0d out_valid", k), 40'(d_ovalid(k)), 40'(m_hold[k]));
        if (m_hold[k]) begin
          chk($sformatf("u%0d out_acc", k), d_acc(k), m_acc(k));
          chk($sformatf("u%0d out_ovf", k), 40'(d_ovf(k)), 40'(m_ovf(k)));
          chk($sformatf("u%0d out_para_mode", k), 40'(d_mode(k)), 40'(m_mode[k]));
        end
      end

  task automatic cyc(int k, bit v, bit md, logic [31:0] p, bit l, bit r);
    if (k == 0) begin
      b0.in_valid = v; b0.in_para_mode = md; b0.in_p = p; b0.in_last = l; b0.out_ready = r;
    end else begin
      b1.in_valid = v; b1.in_para_mode = md; b1.in_p = p; b1.in_last = l; b1.out_ready = r;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pin(int k, string nm, logic [39:0] a, logic [1:0] o, bit md);
    chk({nm, " model hold"}, 40'(m_hold[k]), 40'd1);
    chk({nm, " model acc"}, m_acc(k), a);
    chk({nm, " model ovf"}, 40'(m_ovf(k)), 40'(o));
    chk({nm, " dut acc"}, d_acc(k), a);
    chk({nm, " dut ovf"}, 40'(d_ovf(k)), 40'(o));
    chk({nm, " dut mode"}, 40'(d_mode(k)), 40'(md));
  endtask

  task automatic rst_zero(string nm);
    chk({nm, " in_ready"}, 40'(d_irdy(0)), 40'd0);
    chk({nm, " out_valid"}, 40'(d_ovalid(0)), 40'd0);
    chk({nm, " out_acc"}, d_acc(0), 40'd0);
    chk({nm, " out_ovf"}, 40'(d_ovf(0)), 40'd0);
    chk({nm, " out_para_mode"}, 40'(d_mode(0)), 40'd0);
  endtask

  initial begin
    b0.in_valid = 0; b0.in_para_mode = 0; b0.in_p = 0; b0.in_last = 0; b0.out_ready = 1;
    b1.in_valid = 0; b1.in_para_mode = 0; b1.in_p = 0; b1.in_last = 0; b1.out_ready = 1;
    #2 rst_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 0;
    chk("ready before first edge", 40'(d_irdy(0)), 40'd0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("ready after first edge", 40'(d_irdy(0)), 40'd1);
    // 16-bit full batch, then backpressure
    repeat (4) cyc(0, 1, 0, 32'hFFFE_0001, 0, 0);
    pin(0, "w16", 40'h03_FFF8_0004, 2'b00, 0);
    repeat (5) begin
      cyc(0, 0, 0, 0, 0, 0);
      chk("bp in_ready", 40'(d_irdy(0)), 40'd0);
      chk("bp out_valid", 40'(d_ovalid(0)), 40'd1);
      chk("bp acc", d_acc(0), 40'h03_FFF8_0004);
    end
    // Release and accept the next batch's first beat in the same cycle
    cyc(0, 1, 1, 32'hFE01_FE01, 0, 1);
    chk("zero-bubble out_valid", 40'(d_ovalid(0)), 40'd0);
    repeat (3) cyc(0, 1, 1, 32'hFE01_FE01, 0, 0);
    pin(0, "para", 40'h3F804_3F804, 2'b00, 1);
    cyc(0, 0, 0, 0, 0, 1);
    // Early close with mode flip on the closing beat
    cyc(0, 1, 0, 32'd100, 0, 0);
    cyc(0, 1, 1, 32'd200, 1, 0);
    pin(0, "early", 40'd300, 2'b00, 0);
    cyc(0, 0, 0, 0, 0, 1);
    // Async reset mid-batch
    cyc(0, 1, 1, 32'h1234_5678, 0, 0);
    cyc(0, 1, 1, 32'h1234_5678, 0, 0);
    #2 rst = 1;
    #1 rst_zero("mid rst");
    @(posedge clk);
    #1 rst = 0;
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 32'd1, 0, 0);
    cyc(0, 1, 0, 32'd2, 0, 0);
    cyc(0, 1, 0, 32'd3, 0, 0);
    cyc(0, 1, 0, 32'd4, 1, 0);
    pin(0, "after rst", 40'd10, 2'b00, 0);
    cyc(0, 0, 0, 0, 0, 1);
    // 34-bit instance: lane wrap and chained wrap
    cyc(1, 1, 1, 32'h0001_FE01, 0, 0);
    cyc(1, 1, 1, 32'h0001_FE01, 0, 0);
    cyc(1, 1, 1, 32'h0001_FE01, 1, 0);
    pin(1, "p34", 40'h6_FA03, 2'b01, 1);
    cyc(1, 0, 0, 0, 0, 1);
    repeat (4) cyc(1, 1, 0, 32'hFFFE_0001, 0, 0);
    cyc(1, 1, 0, 32'hFFFE_0001, 1, 0);
    pin(1, "w34", 40'h0_FFF6_0005, 2'b10, 0);
    cyc(1, 0, 0, 0, 0, 1);
    // Random traffic on both instances
    repeat (1500) begin
      b0.in_valid = ($urandom_range(3) != 0); b0.in_para_mode = $urandom_range(1);
      b0.in_p = ($urandom_range(3) == 0) ? 32'hFFFF_FFFF : $urandom;
      b0.in_last = ($urandom_range(5) == 0); b0.out_ready = ($urandom_range(2) != 0);
      b1.in_valid = ($urandom_range(3) != 0); b1.in_para_mode = $urandom_range(1);
      b1.in_p = ($urandom_range(3) == 0) ? 32'hFFFF_FFFF : $urandom;
      b1.in_last = ($urandom_range(7) == 0); b1.out_ready = ($urandom_range(2) != 0);
      @(posedge clk);
      #1;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
